rr_arb_mux: RTL and testbench

//  Parametrised N-channel, WIDTH-bit multiplexer with round-robin arbitration and one registered output stage.

---
 rtl/rr_arb_mux_if.sv | 38 +++
 rtl/rr_arb_mux.sv | 96 +++++++++
 tb/tb_rr_arb_mux.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/rr_arb_mux_if.sv
// Handshake bundle for rr_arb_mux: producer valid/ready/data, registered consumer side.
// Optional force_en/force_sel members exist only when ARB_MUX_FORCE_EN is defined.
interface rr_arb_mux_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4
);
  localparam int SELW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_sel;
  logic               out_ready;
`ifdef ARB_MUX_FORCE_EN
  logic               force_en;
  logic [SELW-1:0]    force_sel;

  modport master (
    output in_valid, in_data, out_ready, force_en, force_sel,
    input  in_ready, out_valid, out_data, out_sel
  );
  modport slave (
    input  in_valid, in_data, out_ready, force_en, force_sel,
    output in_ready, out_valid, out_data, out_sel
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
`endif
endinterface

// File: rtl/rr_arb_mux.sv
// N-channel round-robin arbiter feeding a single registered output stage (latency 1, 1 word/cycle).
// Define ARB_MUX_FORCE_EN to add force_en/force_sel arbitration override.
module rr_arb_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 4
) (
  input logic         clk,
  input logic         rst_n,
  rr_arb_mux_if.slave bus
);
  localparam int SELW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [SELW-1:0]  rr_ptr;
  logic [SELW-1:0]  grant;
  logic [SELW-1:0]  next_ptr;
  logic [SELW-1:0]  sel_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] sel_data;
  logic [N-1:0]     eligible;
  logic [N-1:0]     rot;
  logic             found;
  logic             load;
  logic             ptr_hold;
  logic             out_valid;
  int               idx;
  logic [WIDTH-1:0] chan_data [N];

  for (genvar i = 0; i < N; i++) begin : g_chan
    assign chan_data[i] = bus.in_data[i*WIDTH +: WIDTH];
  end

`ifdef ARB_MUX_FORCE_EN
  logic [N-1:0] force_mask;
  // An out-of-range forced index masks every channel, so nothing is granted.
  assign force_mask = (int'(bus.force_sel) < N) ? (N'(1) << bus.force_sel) : '0;
  assign eligible   = bus.force_en ? (bus.in_valid & force_mask) : bus.in_valid;
  assign ptr_hold   = bus.force_en;
`else
  assign eligible   = bus.in_valid;
  assign ptr_hold   = 1'b0;
`endif

  // Search starts at rr_ptr and wraps at N-1, so non-power-of-two N never visits a missing channel.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    rot   = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N) idx = idx - N;
      rot = eligible >> idx;
      if (!found && rot[0]) begin
        found = 1'b1;
        grant = SELW'(idx);
      end
    end
  end

  assign out_valid    = (state_q == FULL);
  assign load         = rst_n && (!out_valid || bus.out_ready) && found;
  assign next_ptr     = (grant == SELW'(N - 1)) ? '0 : grant + 1'b1;
  assign sel_data     = chan_data[grant];
  assign bus.in_ready = load ? (N'(1) << grant) : '0;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (load) state_d = FULL;
      FULL:    if (!load && bus.out_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
      rr_ptr  <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        data_q <= sel_data;
        sel_q  <= grant;
        if (!ptr_hold) rr_ptr <= next_ptr;
      end
    end
  end
endmodule

// File: tb/tb_rr_arb_mux.sv
// Randomized self-checking bench for rr_arb_mux: an N=4/WIDTH=32 and an N=3/WIDTH=8 instance
// checked every cycle against a queue-free round-robin reference model.
module tb_rr_arb_mux;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rr_arb_mux_if #(.WIDTH(32), .N(4)) bus4 ();
  rr_arb_mux_if #(.WIDTH(8),  .N(3)) bus3 ();

  rr_arb_mux #(.WIDTH(32), .N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  rr_arb_mux #(.WIDTH(8),  .N(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  int          errors = 0;
  int          checks = 0;
  int          nch [2] = '{4, 3};
  int          mptr [2];
  bit          mval [2];
  logic [31:0] mdata [2];
  int          msel [2];
  logic [31:0] chdata [2][4];
  bit          fen = 1'b0;
  int          fsel = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference arbitration: first requesting channel at or after ptr, modulo n.
  function automatic int pickChannel(input int n, input int ptr, input logic [3:0] elig);
    for (int k = 0; k < n; k++) begin
      int c = (ptr + k) % n;
      if (elig[c]) return c;
    end
    return -1;
  endfunction

  task automatic modelReset();
    for (int j = 0; j < 2; j++) begin
      mptr[j] = 0; mval[j] = 1'b0; mdata[j] = '0; msel[j] = 0;
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " n4 in_ready"},  64'(bus4.in_ready),  64'd0);
    checkOutput({tag, " n4 out_valid"}, 64'(bus4.out_valid), 64'd0);
    checkOutput({tag, " n4 out_data"},  64'(bus4.out_data),  64'd0);
    checkOutput({tag, " n4 out_sel"},   64'(bus4.out_sel),   64'd0);
    checkOutput({tag, " n3 in_ready"},  64'(bus3.in_ready),  64'd0);
    checkOutput({tag, " n3 out_valid"}, 64'(bus3.out_valid), 64'd0);
    checkOutput({tag, " n3 out_sel"},   64'(bus3.out_sel),   64'd0);
  endtask

  task automatic driveData();
    for (int i = 0; i < 4; i++) bus4.in_data[i*32 +: 32] = chdata[0][i];
    for (int i = 0; i < 3; i++) bus3.in_data[i*8 +: 8] = chdata[1][i][7:0];
`ifdef ARB_MUX_FORCE_EN
    bus4.force_en = fen; bus4.force_sel = 2'(fsel);
    bus3.force_en = fen; bus3.force_sel = 2'(fsel);
`endif
  endtask

  // One clock of stimulus: grant checked before the edge, registered outputs after it.
  task automatic applyStimulus(input logic [3:0] v4, input logic [2:0] v3, input bit rdy);
    logic [3:0] vj, elig, expReady, gotReady;
    bit         load;
    int         g;
    @(negedge clk);
    bus4.in_valid = v4; bus3.in_valid = v3;
    bus4.out_ready = rdy; bus3.out_ready = rdy;
    driveData();
    #1;
    for (int j = 0; j < 2; j++) begin
      vj = (j == 0) ? v4 : {1'b0, v3};
      if (fen) elig = (fsel < nch[j]) ? (vj & (4'd1 << fsel)) : 4'd0;
      else     elig = vj;
      g        = pickChannel(nch[j], mptr[j], elig);
      load     = (!mval[j] || rdy) && (g >= 0);
      expReady = load ? (4'd1 << g) : 4'd0;
      gotReady = (j == 0) ? bus4.in_ready : {1'b0, bus3.in_ready};
      checkOutput($sformatf("n%0d in_ready", nch[j]), 64'(gotReady), 64'(expReady));
      if (load) begin
        mdata[j] = chdata[j][g]; msel[j] = g; mval[j] = 1'b1;
        if (!fen) mptr[j] = (g + 1) % nch[j];
      end else if (mval[j] && rdy) begin
        mval[j] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    checkOutput("n4 out_valid", 64'(bus4.out_valid), 64'(mval[0]));
    checkOutput("n4 out_data",  64'(bus4.out_data),  64'(mdata[0]));
    checkOutput("n4 out_sel",   64'(bus4.out_sel),   64'(msel[0]));
    checkOutput("n3 out_valid", 64'(bus3.out_valid), 64'(mval[1]));
    checkOutput("n3 out_data",  64'(bus3.out_data),  64'(mdata[1][7:0]));
    checkOutput("n3 out_sel",   64'(bus3.out_sel),   64'(msel[1]));
  endtask

  task automatic resetDut();
    @(negedge clk);
    bus4.in_valid = 4'hF; bus3.in_valid = 3'h7;
    rst_n = 1'b0;
    #1;
    checkResetState("reset");
    modelReset();
    bus4.in_valid = '0; bus3.in_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic setCountData();
    for (int i = 0; i < 4; i++) begin
      chdata[0][i] = 32'h1000_0000 + 32'(i);
      chdata[1][i] = 32'h10 + 32'(i);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    bus4.in_valid = '0; bus4.in_data = '0; bus4.out_ready = 1'b0;
    bus3.in_valid = '0; bus3.in_data = '0; bus3.out_ready = 1'b0;
    driveData();
    modelReset();
    #2 rst_n = 1'b0;
    #1;
    checkResetState("power-on");

    resetDut();
    setCountData();
    for (int c = 0; c < 6; c++) applyStimulus(4'hF, 3'h7, 1'b1);

    for (int i = 0; i < 4; i++) begin
      chdata[0][i] = 32'hDEAD_BEEF;
      chdata[1][i] = 32'hEF;
    end
    applyStimulus(4'hF, 3'h7, 1'b1);
    setCountData();
    for (int c = 0; c < 3; c++) applyStimulus(4'hF, 3'h7, 1'b0);
    for (int c = 0; c < 2; c++) applyStimulus(4'hF, 3'h7, 1'b1);

    resetDut();
    for (int c = 0; c < 4; c++) applyStimulus(4'hF, 3'h7, 1'b1);
    applyStimulus(4'b0100, 3'b100, 1'b1);
    applyStimulus(4'hF, 3'h7, 1'b1);
    applyStimulus(4'b0001, 3'b001, 1'b1);
    applyStimulus(4'b0000, 3'b000, 1'b1);

    applyStimulus(4'hF, 3'h7, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async n4 out_valid", 64'(bus4.out_valid), 64'd0);
    checkOutput("async n3 out_valid", 64'(bus3.out_valid), 64'd0);
    checkOutput("async n4 in_ready",  64'(bus4.in_ready),  64'd0);
    modelReset();
    bus4.in_valid = '0; bus3.in_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

`ifdef ARB_MUX_FORCE_EN
    fen = 1'b1; fsel = 1;
    for (int c = 0; c < 4; c++) applyStimulus(4'hF, 3'h7, 1'b1);
    fsel = 3;
    for (int c = 0; c < 3; c++) applyStimulus(4'hF, 3'h7, 1'b1);
    fen = 1'b0; fsel = 0;
    for (int c = 0; c < 3; c++) applyStimulus(4'hF, 3'h7, 1'b1);
`endif

    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        chdata[0][i] = $urandom;
        chdata[1][i] = $urandom & 32'hFF;
      end
`ifdef ARB_MUX_FORCE_EN
      fen  = ($urandom_range(0, 7) == 0);
      fsel = $urandom_range(0, 3);
`endif
      applyStimulus(4'($urandom), 3'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
